b16_sip_feeder: RTL and testbench

Upstream operand sequencer for the 16-lane bit-serial inner-product stage. It accepts one operand set per valid/ready transfer: 16 parallel activation words and 16 serial-operand words. It double-buffers the sets, holds the activation words stable on the parallel lane bus, and streams the serial operands MSB-first, one bit per lane per cycle. Back-to-back sets stream with no bubble cycles, and frame markers tell the downstream capture logic when a dot product is complete.

---
 rtl/b16_sip_feeder.sv | 154 +++++++++++++++
 tb/tb_b16_sip_feeder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/b16_sip_feeder.sv
// ---------------------------------------------------------------------------
// b16_sip_feeder
//
// Operand sequencer for the 16-lane bit-serial inner-product stage. Accepts one
// operand set (parallel activation words + serial operand words) per
// valid/ready transfer. It double-buffers sets (active + shadow), holds the
// active activation words on lane_act, and streams the serial operands
// MSB-first, one bit per lane per cycle, with no bubbles between frames.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   s_valid    operand set offered
//   s_ready    feeder can accept a set (= shadow slot empty)
//   s_act      LANES x W_ACT activation words, lane i at [i*W_ACT +: W_ACT]
//   s_ser      LANES x W_SER serial operand words, lane i at [i*W_SER +: W_SER]
//   lane_act   parallel operand bus to the inner-product stage
//   lane_bit   current serial bit per lane (0 when idle)
//   bit_valid  lane_bit carries a live bit
//   first      live bit is the MSB of a frame
//   last       live bit is the LSB of a frame
//   busy       frame streaming or shadow set held
// ---------------------------------------------------------------------------
module b16_sip_feeder #(
    parameter int LANES = 16,
    parameter int W_ACT = 16,
    parameter int W_SER = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [LANES*W_ACT-1:0]   s_act,
    input  logic [LANES*W_SER-1:0]   s_ser,
    output logic [LANES*W_ACT-1:0]   lane_act,
    output logic [LANES-1:0]         lane_bit,
    output logic                     bit_valid,
    output logic                     first,
    output logic                     last,
    output logic                     busy
);

    localparam int CW = (W_SER > 1) ? $clog2(W_SER) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W_SER - 1);

    typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

    state_t                   state_reg, state_next;
    logic [CW-1:0]            cnt_reg, cnt_next;
    logic                     shad_full_reg, shad_full_next;
    logic [LANES*W_ACT-1:0]   act_reg, act_shad_reg;
    logic [LANES*W_SER-1:0]   ser_reg, ser_shad_reg;

    logic                     xfer;
    logic                     load_act_from_in;
    logic                     load_act_from_shad;
    logic                     load_shad;
    logic [CW-1:0]            bit_idx;

    // Ready depends only on the shadow flag, never on s_valid.
    assign s_ready = !shad_full_reg;
    assign xfer    = s_valid && !shad_full_reg;

    always_comb begin
        state_next         = state_reg;
        cnt_next           = cnt_reg;
        shad_full_next     = shad_full_reg;
        load_act_from_in   = 1'b0;
        load_act_from_shad = 1'b0;
        load_shad          = 1'b0;
        case (state_reg)
            IDLE: begin
                if (xfer) begin
                    load_act_from_in = 1'b1;
                    cnt_next         = '0;
                    state_next       = STREAM;
                end
            end
            STREAM: begin
                if (cnt_reg != CNT_LAST) begin
                    cnt_next = cnt_reg + 1'b1;
                    if (xfer) begin
                        load_shad      = 1'b1;
                        shad_full_next = 1'b1;
                    end
                end else if (shad_full_reg) begin
                    // Shadow promotes on the LSB edge; s_ready is low so no
                    // new transfer can collide with it.
                    load_act_from_shad = 1'b1;
                    shad_full_next     = 1'b0;
                    cnt_next           = '0;
                end else if (xfer) begin
                    // Offer arriving exactly on the LSB edge bypasses the
                    // shadow and keeps the stream gapless.
                    load_act_from_in = 1'b1;
                    cnt_next         = '0;
                end else begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            shad_full_reg <= 1'b0;
            act_reg       <= '0;
            ser_reg       <= '0;
            act_shad_reg  <= '0;
            ser_shad_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            shad_full_reg <= shad_full_next;
            if (load_act_from_in) begin
                act_reg <= s_act;
                ser_reg <= s_ser;
            end else if (load_act_from_shad) begin
                act_reg <= act_shad_reg;
                ser_reg <= ser_shad_reg;
            end
            if (load_shad) begin
                act_shad_reg <= s_act;
                ser_shad_reg <= s_ser;
            end
        end
    end

    // MSB-first: bit index counts down as cnt counts up.
    assign bit_idx = CNT_LAST - cnt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [W_SER-1:0] ser_word;
            assign ser_word     = ser_reg[gi*W_SER +: W_SER];
            assign lane_bit[gi] = (state_reg == STREAM) ? ser_word[bit_idx] : 1'b0;
        end
    endgenerate

    assign lane_act  = act_reg;
    assign bit_valid = (state_reg == STREAM);
    assign first     = bit_valid && (cnt_reg == '0);
    assign last      = bit_valid && (cnt_reg == CNT_LAST);
    assign busy      = bit_valid || shad_full_reg;

endmodule

// File: tb/tb_b16_sip_feeder.sv
// ---------------------------------------------------------------------------
// tb_b16_sip_feeder
//
// Self-checking bench for b16_sip_feeder. The reference model treats the
// feeder as a two-deep queue of operand sets whose head is streamed one bit
// per cycle; the downstream accumulator is rebuilt from the observed lane
// outputs and compared with the plain dot product at every frame's LSB.
// ---------------------------------------------------------------------------
module tb_b16_sip_feeder;

    localparam int LANES = 16;
    localparam int W_ACT = 16;
    localparam int W_SER = 8;
    localparam int AW    = LANES * W_ACT;
    localparam int SW    = LANES * W_SER;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [AW-1:0]   s_act = '0;
    logic [SW-1:0]   s_ser = '0;
    logic [AW-1:0]   lane_act;
    logic [LANES-1:0] lane_bit;
    logic            bit_valid;
    logic            first;
    logic            last;
    logic            busy;

    always #5 clk = ~clk;

    b16_sip_feeder #(.LANES(LANES), .W_ACT(W_ACT), .W_SER(W_SER)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_act     (s_act),
        .s_ser     (s_ser),
        .lane_act  (lane_act),
        .lane_bit  (lane_bit),
        .bit_valid (bit_valid),
        .first     (first),
        .last      (last),
        .busy      (busy)
    );

    typedef struct packed {
        logic [AW-1:0] act;
        logic [SW-1:0] ser;
    } set_t;

    set_t            q[$];          // accepted sets, head is streaming
    int              pos;           // bits of the head already streamed
    logic [AW-1:0]   last_act;      // act of the most recently retired set
    longint unsigned acc;           // downstream accumulator rebuilt from outputs
    int              checks = 0;
    int              errors = 0;

    task automatic check(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic longint unsigned dot(input set_t st);
        longint unsigned sum = 0;
        for (int i = 0; i < LANES; i++)
            sum += longint'(st.act[i*W_ACT +: W_ACT]) * longint'(st.ser[i*W_SER +: W_SER]);
        return sum;
    endfunction

    function automatic set_t rand_set();
        set_t st;
        for (int i = 0; i < LANES; i++) begin
            st.act[i*W_ACT +: W_ACT] = W_ACT'($urandom);
            st.ser[i*W_SER +: W_SER] = W_SER'($urandom);
        end
        return st;
    endfunction

    // Called at a falling edge: compare outputs against the model, drive the
    // next inputs, advance the model across the coming rising edge.
    task automatic step(input logic v, input set_t st, output bit taken);
        bit              streaming;
        logic [LANES-1:0] exp_bits;
        logic [AW-1:0]   exp_act;
        longint unsigned contrib;
        streaming = (q.size() > 0);
        exp_bits  = '0;
        exp_act   = last_act;
        if (streaming) begin
            exp_act = q[0].act;
            for (int i = 0; i < LANES; i++)
                exp_bits[i] = q[0].ser[i*W_SER + (W_SER - 1 - pos)];
        end
        check("s_ready",   AW'(s_ready),   AW'(q.size() < 2));
        check("bit_valid", AW'(bit_valid), AW'(streaming));
        check("first",     AW'(first),     AW'(streaming && pos == 0));
        check("last",      AW'(last),      AW'(streaming && pos == W_SER - 1));
        check("busy",      AW'(busy),      AW'(streaming));
        check("lane_act",  lane_act,       exp_act);
        check("lane_bit",  AW'(lane_bit),  AW'(exp_bits));

        contrib = 0;
        for (int i = 0; i < LANES; i++)
            if (lane_bit[i]) contrib += longint'(lane_act[i*W_ACT +: W_ACT]);
        if (streaming && pos == 0) acc = contrib;
        else                      acc = (acc << 1) + contrib;
        if (streaming && pos == W_SER - 1)
            check("dot", AW'(acc), AW'(dot(q[0])));

        s_valid = v;
        s_act   = st.act;
        s_ser   = st.ser;
        taken   = v && (q.size() < 2);
        if (streaming) begin
            pos++;
            if (pos == W_SER) begin
                last_act = q[0].act;
                void'(q.pop_front());
                pos = 0;
            end
        end
        if (taken) q.push_back(st);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit   tk;
        set_t z;
        z = '0;
        for (int i = 0; i < n; i++) step(1'b0, z, tk);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        #2;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        #1;
        check("rst_s_ready",   AW'(s_ready),   AW'(1));
        check("rst_bit_valid", AW'(bit_valid), AW'(0));
        check("rst_first",     AW'(first),     AW'(0));
        check("rst_last",      AW'(last),      AW'(0));
        check("rst_busy",      AW'(busy),      AW'(0));
        check("rst_lane_bit",  AW'(lane_bit),  AW'(0));
        check("rst_lane_act",  lane_act,       AW'(0));
        q.delete();
        pos      = 0;
        last_act = '0;
        acc      = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        set_t a, b;
        set_t bp[3];
        bit   tk;
        int   tries;
        int   thresh[4] = '{30, 70, 100, 90};

        pos = 0; last_act = '0; acc = 0;
        do_reset();

        // Single frame: lane0 act=3 ser=0x81 -> dot 387
        a = '0;
        a.act[W_ACT-1:0] = W_ACT'(3);
        a.ser[W_SER-1:0] = W_SER'(8'h81);
        step(1'b1, a, tk);
        check("single_taken", AW'(tk), AW'(1));
        idle(10);

        // All lanes saturated
        for (int i = 0; i < LANES; i++) begin
            a.act[i*W_ACT +: W_ACT] = '1;
            a.ser[i*W_SER +: W_SER] = '1;
        end
        check("allones_dot", AW'(dot(a)), AW'(64'd267382800));
        step(1'b1, a, tk);
        idle(10);

        // Back-to-back pair
        a = rand_set();
        b = rand_set();
        step(1'b1, a, tk);
        step(1'b1, b, tk);
        check("b2b_taken", AW'(tk), AW'(1));
        idle(18);

        // Backpressure: valid held across three sets
        for (int k = 0; k < 3; k++) bp[k] = rand_set();
        for (int k = 0; k < 3; k++) begin
            tries = 0;
            do begin
                step(1'b1, bp[k], tk);
                tries++;
            end while (!tk && tries < 30);
            check("bp_accept", AW'(tk), AW'(1));
        end
        idle(26);

        // Bypass: second set offered only during the LSB cycle of the first
        a = rand_set();
        b = rand_set();
        step(1'b1, a, tk);
        idle(W_SER - 1);
        step(1'b1, b, tk);
        check("bypass_taken", AW'(tk), AW'(1));
        idle(10);

        // Reset mid-frame at bit 4 with shadow full
        a = rand_set();
        b = rand_set();
        step(1'b1, a, tk);
        step(1'b1, b, tk);
        idle(3);
        check("pre_rst_busy", AW'(busy), AW'(1));
        do_reset();
        idle(3);
        a = rand_set();
        step(1'b1, a, tk);
        idle(10);

        // Randomized traffic with varying offer density
        for (int n = 0; n < 400; n++) begin
            a = rand_set();
            step(($urandom_range(0, 99) < thresh[n / 100]) ? 1'b1 : 1'b0, a, tk);
        end
        idle(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
